// File: rtl/ex_int_mdu_pkg.sv
// Shared definitions for the integer multiply/divide unit: funct3 encodings,
// divider FSM states and default widths.
package ex_int_mdu_pkg;

  localparam int MDU_XLEN           = 32;
  localparam int MDU_TAG_WIDTH      = 6;
  localparam int PRF_INT_INDEX_SIZE = 7;

  localparam logic [2:0] MDU_OP_MUL    = 3'b000;
  localparam logic [2:0] MDU_OP_MULH   = 3'b001;
  localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [2:0] MDU_OP_DIV    = 3'b100;
  localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [2:0] MDU_OP_REM    = 3'b110;
  localparam logic [2:0] MDU_OP_REMU   = 3'b111;

  localparam int MDU_DIV_LATENCY = MDU_XLEN + 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } mdu_div_state_t;

  function automatic logic mdu_is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/ex_int_mdu_divider.sv
// Iterative restoring divider, one quotient bit per cycle, RISC-V special cases.
// MDU_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
module mdu_divider
  import ex_int_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear_en,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_div_state_t  state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div0_q, div0_d, ovf_q, ovf_d, quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

  logic            is_signed_s, neg_a_s, neg_b_s, div0_s, ovf_s;
  logic [XLEN:0]   rem_sh_s, diff_s;
  logic [XLEN-1:0] quo_fix_s, rem_fix_s;

  always_comb begin
    is_signed_s = ~op_q[0];
    neg_a_s     = is_signed_s & a_q[XLEN-1];
    neg_b_s     = is_signed_s & b_q[XLEN-1];
    div0_s      = (b_q == '0);
    ovf_s       = is_signed_s & (a_q == INT_MIN) & (b_q == '1);
    rem_sh_s    = {rem_q, quo_q[XLEN-1]};
    diff_s      = rem_sh_s - {1'b0, b_q};
  end

  // Next-state and datapath update for the divide sequence.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETUP;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        // a_q stays raw: it is the remainder for a divide by zero.
        quo_d     = neg_a_s ? -a_q : a_q;
        b_d       = neg_b_s ? -b_q : b_q;
        rem_d     = '0;
        cnt_d     = CW'(XLEN - 1);
        div0_d    = div0_s;
        ovf_d     = ovf_s;
        quo_neg_d = neg_a_s ^ neg_b_s;
        rem_neg_d = neg_a_s;
`ifdef MDU_EARLY_OUT_EN
        state_d   = (div0_s | ovf_s) ? FIX : ITER;
`else
        state_d   = ITER;
`endif
      end
      ITER: begin
        if (!diff_s[XLEN]) begin
          rem_d = diff_s[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh_s[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? FIX : ITER;
      end
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear_en) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Divider state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  // Sign application and special-case overrides, valid in FIX.
  always_comb begin
    quo_fix_s = quo_neg_q ? -quo_q : quo_q;
    rem_fix_s = rem_neg_q ? -rem_q : rem_q;
    if (div0_q) begin
      result = op_q[1] ? a_q : '1;
    end else if (ovf_q) begin
      result = op_q[1] ? '0 : INT_MIN;
    end else begin
      result = op_q[1] ? rem_fix_s : quo_fix_s;
    end
  end

  assign busy = (state_q == SETUP) | (state_q == ITER) | (state_q == FIX);
  // Result is presented in FIX so the top-level output register shows it in DONE.
  assign done = (state_q == FIX);

endmodule

// File: rtl/ex_int_mdu.sv
// Issue-pipe-2 multiply/divide unit: pipelined multiplier, iterative divider, shared output.
// MDU_EARLY_OUT_EN (in mdu_divider) shortens divide-by-zero / overflow latency to 3.
module ex_int_mdu
  import ex_int_mdu_pkg::*;
#(
  parameter int XLEN        = MDU_XLEN,
  parameter int TAG_WIDTH   = MDU_TAG_WIDTH,
  parameter int MUL_LATENCY = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear_en,
  input  logic                          in_valid,
  input  logic [2:0]                    in_funct3,
  input  logic [XLEN-1:0]               in_rs1_value,
  input  logic [XLEN-1:0]               in_rs2_value,
  input  logic [PRF_INT_INDEX_SIZE-1:0] in_rd_index,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          busy,
  output logic                          out_valid,
  output logic [PRF_INT_INDEX_SIZE-1:0] out_rd_index,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [XLEN-1:0]               out_result
);

  logic accept_s, mul_accept_s, div_start_s, div_done_s;
  logic sign_a_s, sign_b_s;
  logic [XLEN:0]     a_ext_s, b_ext_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res_s, div_res_s;

  logic                          mul_nxt_v_s;
  logic [XLEN-1:0]               mul_nxt_res_s;
  logic [PRF_INT_INDEX_SIZE-1:0] mul_nxt_rd_s;
  logic [TAG_WIDTH-1:0]          mul_nxt_tag_s;

  logic [PRF_INT_INDEX_SIZE-1:0] div_rd_q, div_rd_d;
  logic [TAG_WIDTH-1:0]          div_tag_q, div_tag_d;
  logic                          out_valid_q, out_valid_d;
  logic [PRF_INT_INDEX_SIZE-1:0] out_rd_q, out_rd_d;
  logic [TAG_WIDTH-1:0]          out_tag_q, out_tag_d;
  logic [XLEN-1:0]               out_res_q, out_res_d;

  assign accept_s     = in_valid & ~busy & ~clear_en;
  assign mul_accept_s = accept_s & ~mdu_is_div(in_funct3);
  assign div_start_s  = accept_s & mdu_is_div(in_funct3);

  // XLEN+1-bit operand extension; the 2*XLEN product is exact modulo 2^(2*XLEN).
  always_comb begin
    sign_a_s  = (in_funct3 == MDU_OP_MULH) | (in_funct3 == MDU_OP_MULHSU);
    sign_b_s  = (in_funct3 == MDU_OP_MULH);
    a_ext_s   = {sign_a_s & in_rs1_value[XLEN-1], in_rs1_value};
    b_ext_s   = {sign_b_s & in_rs2_value[XLEN-1], in_rs2_value};
    prod_s    = {{(XLEN-1){a_ext_s[XLEN]}}, a_ext_s} * {{(XLEN-1){b_ext_s[XLEN]}}, b_ext_s};
    mul_res_s = (in_funct3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  if (MUL_LATENCY > 1) begin : g_pipe
    localparam int NS = MUL_LATENCY - 1;
    logic [NS-1:0]                 v_q, v_d;
    logic [XLEN-1:0]               res_q [NS];
    logic [XLEN-1:0]               res_d [NS];
    logic [PRF_INT_INDEX_SIZE-1:0] rd_q  [NS];
    logic [PRF_INT_INDEX_SIZE-1:0] rd_d  [NS];
    logic [TAG_WIDTH-1:0]          tag_q [NS];
    logic [TAG_WIDTH-1:0]          tag_d [NS];

    // Shift the multiply stages; a flush kills every in-flight valid.
    always_comb begin
      v_d[0]   = mul_accept_s;
      res_d[0] = mul_res_s;
      rd_d[0]  = in_rd_index;
      tag_d[0] = in_tag;
      for (int i = 1; i < NS; i++) begin
        v_d[i]   = v_q[i-1] & ~clear_en;
        res_d[i] = res_q[i-1];
        rd_d[i]  = rd_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end

    // Multiply stage registers.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v_q   <= '0;
        res_q <= '{default: '0};
        rd_q  <= '{default: '0};
        tag_q <= '{default: '0};
      end else begin
        v_q   <= v_d;
        res_q <= res_d;
        rd_q  <= rd_d;
        tag_q <= tag_d;
      end
    end

    assign mul_nxt_v_s   = v_q[NS-1];
    assign mul_nxt_res_s = res_q[NS-1];
    assign mul_nxt_rd_s  = rd_q[NS-1];
    assign mul_nxt_tag_s = tag_q[NS-1];
  end else begin : g_nopipe
    assign mul_nxt_v_s   = mul_accept_s;
    assign mul_nxt_res_s = mul_res_s;
    assign mul_nxt_rd_s  = in_rd_index;
    assign mul_nxt_tag_s = in_tag;
  end

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clock    (clock),
    .reset    (reset),
    .clear_en (clear_en),
    .start    (div_start_s),
    .op       (in_funct3[1:0]),
    .a        (in_rs1_value),
    .b        (in_rs2_value),
    .busy     (busy),
    .done     (div_done_s),
    .result   (div_res_s)
  );

  // Divide shadow registers and the shared output register; outputs hold when idle.
  always_comb begin
    div_rd_d    = div_start_s ? in_rd_index : div_rd_q;
    div_tag_d   = div_start_s ? in_tag : div_tag_q;
    out_valid_d = (div_done_s | mul_nxt_v_s) & ~clear_en;
    if (clear_en) begin
      out_rd_d  = out_rd_q;
      out_tag_d = out_tag_q;
      out_res_d = out_res_q;
    end else if (div_done_s) begin
      out_rd_d  = div_rd_q;
      out_tag_d = div_tag_q;
      out_res_d = div_res_s;
    end else if (mul_nxt_v_s) begin
      out_rd_d  = mul_nxt_rd_s;
      out_tag_d = mul_nxt_tag_s;
      out_res_d = mul_nxt_res_s;
    end else begin
      out_rd_d  = out_rd_q;
      out_tag_d = out_tag_q;
      out_res_d = out_res_q;
    end
  end

  // Output and shadow registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_rd_q    <= '0;
      div_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_tag_q   <= '0;
      out_res_q   <= '0;
    end else begin
      div_rd_q    <= div_rd_d;
      div_tag_q   <= div_tag_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_tag_q   <= out_tag_d;
      out_res_q   <= out_res_d;
    end
  end

  assign out_valid    = out_valid_q & ~clear_en;
  assign out_rd_index = out_rd_q;
  assign out_tag      = out_tag_q;
  assign out_result   = out_res_q;

endmodule

// File: tb/tb_ex_int_mdu.sv
// Scoreboard bench for ex_int_mdu: directed vectors, expected results queued at issue.
module tb_ex_int_mdu;
  import ex_int_mdu_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 35;
`ifdef MDU_EARLY_OUT_EN
  localparam int SPC_LAT = 3;
`else
  localparam int SPC_LAT = 35;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_rs1_value = 32'h0;
  logic [31:0] in_rs2_value = 32'h0;
  logic [6:0]  in_rd_index = 7'h0;
  logic [5:0]  in_tag = 6'h0;
  logic        busy, out_valid;
  logic [6:0]  out_rd_index;
  logic [5:0]  out_tag;
  logic [31:0] out_result;

  ex_int_mdu #(.XLEN(32), .TAG_WIDTH(6), .MUL_LATENCY(MUL_LAT)) dut (
    .clock(clock), .reset(reset), .clear_en(clear_en), .in_valid(in_valid),
    .in_funct3(in_funct3), .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value),
    .in_rd_index(in_rd_index), .in_tag(in_tag), .busy(busy), .out_valid(out_valid),
    .out_rd_index(out_rd_index), .out_tag(out_tag), .out_result(out_result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [6:0]  rd;
    logic [5:0]  tag;
    logic [31:0] res;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented result must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got result 0x%08h tag %0d, required no output (cycle %0d)",
                 out_result, out_tag, cyc);
      end else begin
        e = sb.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_result", out_result, e.res);
        chk("out_tag", {26'h0, out_tag}, {26'h0, e.tag});
        chk("out_rd_index", {25'h0, out_rd_index}, {25'h0, e.rd});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] rd, input logic [5:0] tag,
                       input logic [31:0] exp, input int lat, input bit expect_out);
    in_valid     = 1'b1;
    in_funct3    = f;
    in_rs1_value = a;
    in_rs2_value = b;
    in_rd_index  = rd;
    in_tag       = tag;
    if (expect_out) sb.push_back('{cyc + lat, rd, tag, exp});
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  logic [2:0]  sp_f [6] = '{MDU_OP_DIVU, MDU_OP_REMU, MDU_OP_DIV, MDU_OP_REM, MDU_OP_REM, MDU_OP_DIV};
  logic [31:0] sp_a [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
  logic [31:0] sp_b [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] sp_e [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF};

  initial begin
    int c0;
    int bad;
    #2;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_out_result", out_result, 32'h0);
    chk("reset_out_tag", {26'h0, out_tag}, 32'h0);
    chk("reset_out_rd", {25'h0, out_rd_index}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // MULH of two INT_MIN operands, busy must never rise.
    issue(MDU_OP_MULH, 32'h8000_0000, 32'h8000_0000, 7'd3, 6'd1, 32'h4000_0000, MUL_LAT, 1'b1);
    bad = 0;
    repeat (4) begin
      if (busy !== 1'b0) bad++;
      tick(1);
    end
    chk("mulh_busy_low", bad, 32'h0);

    // Back-to-back multiplies of every flavour.
    issue(MDU_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd4, 6'd2, 32'hFFFF_FFFE, MUL_LAT, 1'b1);
    issue(MDU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd5, 6'd3, 32'hFFFF_FFFF, MUL_LAT, 1'b1);
    issue(MDU_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'd6, 6'd4, 32'h0000_0001, MUL_LAT, 1'b1);
    issue(MDU_OP_MUL,    32'd6,         32'd7,         7'd7, 6'd5, 32'd42,        MUL_LAT, 1'b1);
    tick(5);

    // DIV -7/2, then REM -7/2 issued in the DONE cycle.
    c0 = cyc;
    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 7'd10, 6'd10, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
    bad = 0;
    repeat (34) begin
      if (busy !== 1'b1) bad++;
      tick(1);
    end
    chk("div_busy_window", bad, 32'h0);
    chk("div_done_cycle", cyc - c0, 32'd35);
    chk("busy_low_in_done", {31'h0, busy}, 32'h0);
    issue(MDU_OP_REM, 32'hFFFF_FFF9, 32'd2, 7'd11, 6'd11, 32'hFFFF_FFFF, DIV_LAT, 1'b1);
    tick(DIV_LAT + 2);

    // Special cases: divide by zero and signed overflow.
    for (int i = 0; i < 6; i++) begin
      issue(sp_f[i], sp_a[i], sp_b[i], 7'(20 + i), 6'(20 + i), sp_e[i], SPC_LAT, 1'b1);
      tick(SPC_LAT - 1);
    end
    tick(4);

    // Flush mid-divide with a colliding op presented in the flush cycle.
    c0 = cyc;
    issue(MDU_OP_DIVU, 32'd100, 32'd7, 7'd30, 6'd30, 32'd14, DIV_LAT, 1'b0);
    tick(11);
    clear_en     = 1'b1;
    in_valid     = 1'b1;
    in_funct3    = MDU_OP_MUL;
    in_rs1_value = 32'd3;
    in_rs2_value = 32'd3;
    tick(1);
    clear_en = 1'b0;
    in_valid = 1'b0;
    chk("clear_busy_drop", {31'h0, busy}, 32'h0);
    chk("clear_cycle", cyc - c0, 32'd13);
    tick(30);
    issue(MDU_OP_MUL, 32'd6, 32'd7, 7'd31, 6'd42, 32'd42, MUL_LAT, 1'b1);
    tick(5);

    // Flush in the cycle a multiply result is due: out_valid gated at once.
    issue(MDU_OP_MUL, 32'd9, 32'd9, 7'd32, 6'd33, 32'd81, MUL_LAT, 1'b0);
    tick(MUL_LAT - 1);
    clear_en = 1'b1;
    #1;
    chk("clear_gates_out_valid", {31'h0, out_valid}, 32'h0);
    tick(1);
    clear_en = 1'b0;
    tick(4);

    // Async reset pulse in the middle of a divide.
    issue(MDU_OP_DIV, 32'd1000, 32'd3, 7'd40, 6'd40, 32'd333, DIV_LAT, 1'b0);
    tick(19);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_out_result", out_result, 32'h0);
    chk("async_rst_out_tag", {26'h0, out_tag}, 32'h0);
    #1;
    reset = 1'b0;
    tick(1);
    issue(MDU_OP_DIVU, 32'd100, 32'd7, 7'd41, 6'd41, 32'd14, DIV_LAT, 1'b1);
    tick(DIV_LAT - 1);
    issue(MDU_OP_REMU, 32'd100, 32'd7, 7'd42, 6'd43, 32'd2, DIV_LAT, 1'b1);
    tick(DIV_LAT + 3);

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_int_mdu.md
Name: ex_int_mdu

Overview:
- Integer multiply/divide execution unit behind issue pipe 2, the IMUL/IDIV pipe of the integer issue queue.
- Consumes one issued M-extension op per cycle when idle.
- Drives the pipe-2 bit of the issue queue's ex_busy while a divide is in progress.
- Multiplies use a fixed-latency pipeline; divides use an iterative 1-bit-per-cycle FSM.

Parameters:
- XLEN, 32, operand/result width.
- TAG_WIDTH, 6, width of the opaque tag passed through (ROB index).
- MUL_LATENCY, 3, cycles from accept to multiply result; legal range 1..3.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- clear_en  in  1  synchronous pipeline flush.
- in_valid  in  1  op issued this cycle.
- in_funct3  in  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_rs1_value  in  XLEN  operand A.
- in_rs2_value  in  XLEN  operand B.
- in_rd_index  in  PRF_INT_INDEX_SIZE  destination physical register.
- in_tag  in  TAG_WIDTH  passthrough tag.
- busy  out  1  to ex_busy[2]; high means in_valid must not be asserted.
- out_valid  out  1  result valid, one-cycle pulse per op.
- out_rd_index  out  PRF_INT_INDEX_SIZE  destination of the result.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_result  out  XLEN  result value.

Behaviour:
- Reset (async): all pipeline valids 0, FSM IDLE, busy=0, out_valid=0, out_rd_index=0, out_tag=0, out_result=0.
- Accept: an op is accepted in cycle k iff in_valid & ~busy & ~clear_en. If in_valid is high while busy, the op is ignored (protocol violation).
- Multiply path:
  - Fully pipelined; out_valid in cycle k+MUL_LATENCY.
  - Operands are extended to XLEN+1 bits: signed for MULH, signed×unsigned for MULHSU, unsigned for MULHU; low/high half selected by funct3.
  - One op per cycle is allowed back-to-back.
- Divide FSM, states IDLE -> SETUP -> ITER -> FIX -> DONE -> IDLE:
  - SETUP, 1 cycle: take absolute values for signed ops, latch quotient/remainder signs, detect special cases.
  - ITER, XLEN cycles: restoring shift-subtract with a counter from XLEN-1 down to 0; leave at 0.
  - FIX, 1 cycle: apply signs and special-case overrides.
  - DONE: out_valid=1; FSM returns to IDLE the next cycle.
  - Latency: out_valid in cycle k+XLEN+3 (k+35 at default).
- busy=1 in SETUP, ITER and FIX; busy=0 in IDLE and DONE, so a new op may be accepted in the DONE cycle.
- Special cases (RISC-V semantics):
  - Divide by zero: quotient all ones, remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1), remainder 0.
  - Signed remainder takes the dividend's sign.
- Result port is shared; no collision is possible:
  - While busy, no multiply enters.
  - Any multiply accepted before the divide drains by k+MUL_LATENCY-1, which is earlier than the divide's output cycle.
- clear_en:
  - Forces out_valid=0 in the same cycle (combinational gate).
  - At the next edge, clears all multiply-stage valids, returns the FSM to IDLE and drops busy.
  - An op presented in the same cycle is not accepted.
- Async reset asserted mid-divide: immediate return to IDLE, busy=0; no result is produced.
- out_rd_index, out_tag and out_result hold their last values when out_valid=0.

Optional Feature:
- MDU_EARLY_OUT_EN defined: divide-by-zero and signed overflow are resolved in SETUP, and the FSM jumps SETUP -> FIX, giving out_valid at k+3 and busy high for 2 cycles.
  - Collision-free only if MUL_LATENCY <= 3, which the range limit guarantees.
- Not defined: special cases take the full XLEN+3 latency.

Decomposition:
- Shared package:
  - funct3 constants MDU_OP_MUL ... MDU_OP_REMU.
  - enum mdu_div_state_t {IDLE, SETUP, ITER, FIX, DONE}.
  - MDU_DIV_LATENCY = XLEN+3.
- Sub-module mdu_divider: the FSM plus the quotient/remainder datapath, with start/busy/done handshake.
- The top level holds the multiply pipeline, tag/rd shadow registers and the output mux.

Test Plan:
- MULH 0x80000000 × 0x80000000 at cycle 10 -> out_result 0x40000000 at cycle 13, busy stays 0.
- Back-to-back MULHU 0xFFFFFFFF×0xFFFFFFFF then MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE then 0xFFFFFFFF on consecutive cycles.
- DIV -7/2 at cycle 0, then REM -7/2 issued in the DONE cycle:
  - DIV gives out_result 0xFFFFFFFD at cycle 35.
  - busy is high in cycles 1..34.
  - REM gives 0xFFFFFFFF at cycle 70.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000. Latency 35, or 3 with MDU_EARLY_OUT_EN.
- DIVU 100/7 started, clear_en at cycle 12 -> busy=0 at cycle 13 and no out_valid. A following MUL 6×7 gives 42 with correct tag.
- Async reset pulse at cycle 20 of a divide -> busy and out_valid 0 immediately. The next DIVU 100/7 yields 14 and REMU yields 2.
